// File: rtl/mul_shift_add_if.sv
// Handshake bundle for the shift-add multiplier: start request with
// operands in, registered product with completion pulse and leading-zero count out.
interface mul_shift_add_if #(
  parameter int FPWID = 32
);
  logic                 ld;
  logic [FPWID-1:0]     a;
  logic [FPWID-1:0]     b;
  logic [2*FPWID-1:0]   p;
  logic                 done;
  logic                 busy;
  logic [7:0]           lzcnt;

  modport master (output ld, a, b, input p, done, busy, lzcnt);
  modport slave  (input ld, a, b, output p, done, busy, lzcnt);
endinterface

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-add multiplier with early exit once the remaining
// multiplier bits are zero; one-cycle done pulse and leading-zero count of the product.
module mul_shift_add #(
  parameter int FPWID = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_shift_add_if.slave bus
);
  localparam int PW = 2 * FPWID;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [FPWID-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;
  logic             done_q, done_d;
  logic [7:0]       lz;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          a_d     = PW'(bus.a);
          b_d     = bus.b;
          acc_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        // Early exit: once no multiplier bits remain the accumulator is final.
        if (b_q == '0) begin
          state_d = DONE;
        end else begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
        end
      end
      DONE: begin
        p_d     = acc_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  // Highest set bit wins since later iterations overwrite earlier ones.
  always_comb begin
    lz = 8'(PW);
    for (int i = 0; i < PW; i++) begin
      if (p_q[i]) lz = 8'(PW - 1 - i);
    end
  end

  assign bus.p     = p_q;
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.lzcnt = lz;
endmodule

// File: doc/mul_shift_add.md
# mul_shift_add

Sequential unsigned fixed-point shift-add multiplier, the inverse counterpart of the Goldschmidt divider in the FPU datapath. It accepts a one-cycle `ld` handshake and computes the full double-width product over multiple cycles, exiting early once the remaining multiplier bits are zero. It raises `done` for one cycle and drives a leading-zero count that the float multiplier uses for normalisation. Its port shape matches the divider (`ld`/`a`/`b` in; result/`done`/`lzcnt` out), so either unit drops into the same FPU sequencing logic.

## Interface
- `FPWID`, 32: operand width in bits; legal range 2..127, because `lzcnt` must hold 2*FPWID.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ld`  in  1  start request; sampled only in IDLE.
- `a`  in  FPWID  multiplicand, unsigned.
- `b`  in  FPWID  multiplier, unsigned.
- `p`  out  2*FPWID  product; registered, holds its value until the next completion.
- `done`  out  1  registered one-cycle pulse; `p` is valid and updated in the same cycle.
- `busy`  out  1  high whenever state != IDLE; decoded from the state register.
- `lzcnt`  out  8  leading zeros of `p`; combinational from `p`.

## Operation
- Internal registers:
  - A, 2*FPWID bits: shifted multiplicand.
  - B, FPWID bits: remaining multiplier.
  - P, 2*FPWID bits: accumulator.
  - state: one of IDLE, MUL, DONE.
- IDLE:
  - If `ld`=1: A <= zero-extended `a`; B <= `b`; P <= 0; go to MUL.
  - Otherwise hold.
- MUL:
  - If B==0: go to DONE; no register update.
  - Else: if B[0]==1 then P <= P + A. Then A <= A<<1 and B <= B>>1; stay in MUL.
  - The addition is 2*FPWID wide and can never overflow, because the product fits in 2*FPWID bits.
- DONE: p <= P; `done` <= 1; go to IDLE.
- `done` defaults to 0 every cycle in which it is not set.
- `lzcnt`:
  - Equals the number of zero bits above the most-significant 1 of `p`.
  - `p`==0 gives lzcnt = 2*FPWID.
  - `p`[2*FPWID-1]==1 gives lzcnt = 0.
- `ld` asserted outside IDLE is ignored; it does not queue and does not restart the operation.
- `a`/`b` need to be stable only on the edge that samples `ld`; they are don't-care afterwards.

## Timing
- Reset values: state=IDLE, `p`=0, `done`=0, `busy`=0, `lzcnt`=2*FPWID (because `p`=0). A, B and P are don't-care.
- Let k = number of significant bits of `b` (position of its highest set bit + 1; k=0 when `b`=0). k is the number of MUL steps taken.
- Latency: `ld` is sampled on edge 0, and `done`/`p` change on edge k+2.
  - Minimum is 2 cycles (`b`=0).
  - Maximum is FPWID+2 cycles.
- `busy` is high from edge 0 through edge k+2 and low after it. It is low in the cycle `done` is high.
- Back-to-back: with `ld` held high, a new operation starts on edge k+3, one edge after the previous `done`. There is no extra bubble.
- `p` is stable between `done` pulses; the accumulator is not visible on `p` while the unit is busy.
- Reset mid-operation: the unit returns to IDLE on that edge with `p`=0 and `done`=0. No `done` pulse is produced for the aborted operation.
- `rst` and `ld` high on the same edge: reset wins.

## Test plan
- `a`=3, `b`=5, FPWID=32 (k=3) -> `p`=0x0F; `done` pulses for one cycle 5 cycles after `ld`; `lzcnt`=60; `busy` high for exactly 5 cycles.
- `b`=0, `a`=0xDEADBEEF -> `p`=0; `done` 2 cycles after `ld`; `lzcnt`=64.
- `a`=`b`=0xFFFFFFFF -> `p`=0xFFFFFFFE00000001; `done` 34 cycles after `ld`; `lzcnt`=0.
- Start `a`=7, `b`=9; pulse `ld` again with `a`=1, `b`=1 while busy -> the second `ld` is ignored; `p`=63; exactly one `done`.
- `ld` held high with operands changed right after each `done` -> back-to-back results with no lost cycle. Results must match a reference model for 1000 random operand pairs, each with the latency k+2.
- Assert `rst` 3 cycles into `a`=100, `b`=0x80000000 -> no `done`; `p`=0, `busy`=0, `lzcnt`=64 after the reset edge. A following operation `a`=2, `b`=3 gives `p`=6.
